regs_conf_ctrl: RTL and testbench

- Frame sequencer on the UART side of the REGS_CONF register bank.
- Decodes a byte stream from the UART receiver into the REGS_CONF strobes: shift_rxregs, load_confregs, load_txregs and shift_txregs.
- Drives the UART transmitter to read the configuration frame back out of txdw.
- A frame is NBYTES bytes, MSB-first register order: control, frec_mod, frec_por, im_am, im_fm = 11 bytes.

---
 rtl/regs_conf_ctrl_if.sv | 26 ++
 rtl/regs_conf_ctrl.sv | 99 +++++++++
 tb/tb_regs_conf_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_conf_ctrl_if.sv
// regs_conf_ctrl_if: UART-side byte stream and REGS_CONF strobe bundle of the frame sequencer
interface regs_conf_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rxdw;
  logic       shift_rxregs;
  logic       load_confregs;
  logic       load_txregs;
  logic       shift_txregs;
  logic       tx_start;
  logic       busy;
  logic       err_timeout;
  logic       err_cmd;
  modport master (
    input  rx_data, rx_valid, tx_busy, tx_done,
    output rxdw, shift_rxregs, load_confregs, load_txregs, shift_txregs,
           tx_start, busy, err_timeout, err_cmd
  );
  modport slave (
    output rx_data, rx_valid, tx_busy, tx_done,
    input  rxdw, shift_rxregs, load_confregs, load_txregs, shift_txregs,
           tx_start, busy, err_timeout, err_cmd
  );
endinterface

// File: rtl/regs_conf_ctrl.sv
// regs_conf_ctrl: decodes UART command frames into REGS_CONF strobes and streams txdw back out
module regs_conf_ctrl #(
  parameter int         NBYTES  = 11,
  parameter int         TIMEOUT = 100000,
  parameter logic [7:0] CMD_WR  = 8'h57,
  parameter logic [7:0] CMD_RD  = 8'h52,
  parameter bit         ECHO_WR = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  regs_conf_ctrl_if.master bus
);
  localparam int CW = $clog2(NBYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RX_DATA, LOAD_CONF, LOAD_TX, TX_SEND, TX_WAIT, TX_SHIFT} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          last;
  // last byte of the frame is the one that brings cnt to NBYTES
  always_comb last = cnt == CW'(NBYTES - 1);
  // frame sequencer; every output is a register, strobes default low each cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      tcnt               <= '0;
      bus.rxdw           <= '0;
      bus.shift_rxregs   <= 1'b0;
      bus.load_confregs  <= 1'b0;
      bus.load_txregs    <= 1'b0;
      bus.shift_txregs   <= 1'b0;
      bus.tx_start       <= 1'b0;
      bus.busy           <= 1'b0;
      bus.err_timeout    <= 1'b0;
      bus.err_cmd        <= 1'b0;
    end else begin
      bus.shift_rxregs  <= 1'b0;
      bus.load_confregs <= 1'b0;
      bus.load_txregs   <= 1'b0;
      bus.shift_txregs  <= 1'b0;
      bus.tx_start      <= 1'b0;
      bus.err_timeout   <= 1'b0;
      bus.err_cmd       <= 1'b0;
      case (state)
        IDLE:
          if (bus.rx_valid) begin
            if (bus.rx_data == CMD_WR) begin
              state    <= RX_DATA;
              cnt      <= '0;
              tcnt     <= '0;
              bus.busy <= 1'b1;
            end else if (bus.rx_data == CMD_RD) begin
              state    <= LOAD_TX;
              bus.busy <= 1'b1;
            end else bus.err_cmd <= 1'b1;
          end
        RX_DATA:
          if (bus.rx_valid) begin
            bus.rxdw         <= bus.rx_data;
            bus.shift_rxregs <= 1'b1;
            cnt              <= cnt + 1'b1;
            tcnt             <= '0;
            if (last) state <= LOAD_CONF;
          end else if (tcnt == TW'(TIMEOUT - 2)) begin
            bus.err_timeout <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end else tcnt <= tcnt + 1'b1;
        LOAD_CONF: begin
          bus.load_confregs <= 1'b1;
          bus.busy          <= ECHO_WR;
          state             <= ECHO_WR ? LOAD_TX : IDLE;
        end
        LOAD_TX: begin
          bus.load_txregs <= 1'b1;
          cnt             <= '0;
          state           <= TX_SEND;
        end
        TX_SEND:
          if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            state        <= TX_WAIT;
          end
        TX_WAIT:
          if (bus.tx_done) state <= TX_SHIFT;
        TX_SHIFT: begin
          bus.shift_txregs <= 1'b1;
          cnt              <= cnt + 1'b1;
          bus.busy         <= !last;
          state            <= last ? IDLE : TX_SEND;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_regs_conf_ctrl.sv
// tb_regs_conf_ctrl: directed frame sequences against an echo instance and a no-echo instance
module tb_regs_conf_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  regs_conf_ctrl_if b ();
  regs_conf_ctrl_if n ();

  regs_conf_ctrl #(.TIMEOUT(50), .ECHO_WR(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(b.master));
  regs_conf_ctrl #(.TIMEOUT(50), .ECHO_WR(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(n.master));

  assign n.rx_data  = b.rx_data;
  assign n.rx_valid = b.rx_valid;
  assign n.tx_busy  = 1'b0;
  assign n.tx_done  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // REGS_CONF model: 11-byte rx chain, config copy, tx chain whose top byte is txdw
  logic [87:0] rxr = '0, conf = '0, txr = '0;
  always @(posedge clk) begin
    if (b.shift_rxregs) rxr <= {rxr[79:0], b.rxdw};
    if (b.load_confregs) conf <= rxr;
    if (b.load_txregs) txr <= conf;
    if (b.shift_txregs) txr <= {txr[79:0], 8'h00};
  end

  // transmitter model: busy 20 cycles per byte, then a one-cycle done
  int tx_cnt = 0;
  initial begin
    b.tx_busy = 1'b0;
    b.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      b.tx_done = 1'b0;
      if (tx_cnt != 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          b.tx_busy = 1'b0;
          b.tx_done = 1'b1;
        end
      end else if (b.tx_start) begin
        b.tx_busy = 1'b1;
        tx_cnt    = 20;
      end
    end
  end

  // event monitor: strobe counts, cycle stamps and the txdw seen at each start
  int n_srx = 0, n_ld = 0, n_ltx = 0, n_stx = 0, n_st = 0, n_to = 0, n_ec = 0, n_multi = 0;
  int nn_srx = 0, nn_ld = 0, nn_tx = 0;
  int ld_cyc = 0, ltx_cyc = 0, stx_cyc = 0, bfall_cyc = 0;
  logic bprev = 1'b0;
  logic [7:0] txq[$], nrxq[$];
  int srxc[$];
  always @(negedge clk) begin
    if (b.shift_rxregs) begin n_srx++; srxc.push_back(cyc); end
    if (b.load_confregs) begin n_ld++; ld_cyc = cyc; end
    if (b.load_txregs) begin n_ltx++; ltx_cyc = cyc; end
    if (b.shift_txregs) begin n_stx++; stx_cyc = cyc; end
    if (b.tx_start) begin n_st++; txq.push_back(txr[87:80]); end
    if (b.err_timeout) n_to++;
    if (b.err_cmd) n_ec++;
    if (bprev && !b.busy) bfall_cyc = cyc;
    bprev = b.busy;
    if ($countones({b.shift_rxregs, b.load_confregs, b.load_txregs, b.shift_txregs}) > 1 ||
        (b.tx_start && b.shift_txregs) ||
        $countones({n.shift_rxregs, n.load_confregs, n.load_txregs, n.shift_txregs}) > 1) n_multi++;
    if (n.shift_rxregs) begin nn_srx++; nrxq.push_back(n.rxdw); end
    if (n.load_confregs) nn_ld++;
    if (n.load_txregs || n.tx_start) nn_tx++;
  end

  int n_assert = 0, n_fail = 0;
  int rv = 0;
  int rvq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v);
    @(negedge clk);
    b.rx_data  = v;
    b.rx_valid = 1'b1;
    rv         = cyc;
    @(negedge clk);
    b.rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] base, input int nb);
    send(8'h57);
    for (int i = 0; i < nb; i++) begin
      repeat (2) @(negedge clk);
      send(base + 8'(i));
      rvq.push_back(rv);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (b.busy !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " idle"}, 32'(k < 1000), 1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int base, s_srx, s_ld, s_ltx, s_ec, r, k;
  initial begin
    rst_n      = 1'b0;
    b.rx_data  = 8'h00;
    b.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {b.rxdw, b.shift_rxregs, b.load_confregs, b.load_txregs, b.shift_txregs,
                          b.tx_start, b.busy, b.err_timeout, b.err_cmd}, 0);
    chk("reset outputs noecho", {n.rxdw, n.shift_rxregs, n.load_confregs, n.busy}, 0);
    rst_n = 1'b1;

    // write with and without echo
    frame(8'h01, 11);
    @(negedge clk);
    chk("noecho load", n.load_confregs, 1);
    chk("noecho busy low", n.busy, 0);
    wait_idle("echo write");
    chk("noecho shifts", nn_srx, 11);
    chk("noecho loads", nn_ld, 1);
    chk("noecho no tx", nn_tx, 0);
    for (int i = 0; i < 11; i++) begin
      chk("rxdw order", nrxq[i], 32'(i + 1));
      chk("shift latency", srxc[i], rvq[i] + 1);
    end
    chk("load after last shift", ld_cyc, srxc[10] + 1);
    chk("r_control", conf[87:80], 8'h01);
    chk("r_im_fm", conf[15:0], 16'h0A0B);
    chk("echo load_txregs", n_ltx, 1);
    chk("echo ltx timing", ltx_cyc, ld_cyc + 1);
    chk("echo starts", n_st, 11);
    chk("echo shifts", n_stx, 11);
    for (int i = 0; i < 11; i++) chk("echo txdw", txq[i], 32'(i + 1));
    chk("busy fall", bfall_cyc, stx_cyc);

    // read only
    base = txq.size(); s_srx = n_srx; s_ld = n_ld; s_ltx = n_ltx;
    send(8'h52);
    r = rv;
    wait_idle("read");
    chk("read ltx timing", ltx_cyc, r + 2);
    chk("read ltx count", n_ltx - s_ltx, 1);
    chk("read no shift_rxregs", n_srx - s_srx, 0);
    chk("read no load", n_ld - s_ld, 0);
    chk("read byte count", txq.size() - base, 11);
    for (int i = 0; i < 11; i++) chk("read txdw", txq[base + i], 32'(i + 1));

    // timeout, then a recovery frame whose payload holds both command values
    s_srx = n_srx; s_ld = n_ld;
    frame(8'hAA, 4);
    r = rv;
    k = 0;
    while (b.err_timeout !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("timeout seen", 32'(k < 200), 1);
    chk("timeout delay", cyc - r, 50);
    chk("timeout idle", b.busy, 0);
    @(negedge clk);
    #1;
    chk("timeout one pulse", b.err_timeout, 0);
    chk("timeout count", n_to, 1);
    chk("timeout shifts", n_srx - s_srx, 4);
    chk("timeout no load", n_ld - s_ld, 0);
    base = txq.size(); s_ld = n_ld;
    frame(8'h4E, 11);
    wait_idle("recovery");
    chk("recovery load", n_ld - s_ld, 1);
    chk("recovery r_control", conf[87:80], 8'h4E);
    chk("recovery r_im_fm", conf[15:0], 16'h5758);
    chk("recovery byte count", txq.size() - base, 11);
    for (int i = 0; i < 11; i++) chk("recovery txdw", txq[base + i], 32'(8'h4E + i));

    // bad command
    s_ec = n_ec;
    send(8'h33);
    chk("err_cmd pulse", b.err_cmd, 1);
    chk("err_cmd busy low", b.busy, 0);
    @(negedge clk);
    #1;
    chk("err_cmd one cycle", b.err_cmd, 0);
    chk("err_cmd count", n_ec - s_ec, 1);

    // rx traffic during TX_WAIT is ignored
    base = txq.size(); s_srx = n_srx; s_ltx = n_ltx; s_ec = n_ec;
    send(8'h52);
    k = 0;
    while (b.tx_start !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("overrun start seen", 32'(k < 50), 1);
    repeat (3) @(negedge clk);
    send(8'h57);
    send(8'h33);
    send(8'h01);
    wait_idle("overrun");
    chk("overrun no shift_rxregs", n_srx - s_srx, 0);
    chk("overrun no err_cmd", n_ec - s_ec, 0);
    chk("overrun one ltx", n_ltx - s_ltx, 1);
    chk("overrun byte count", txq.size() - base, 11);
    for (int i = 0; i < 11; i++) chk("overrun txdw", txq[base + i], 32'(8'h4E + i));

    // reset mid-frame, right while the 6th shift strobe is high
    s_srx = n_srx; s_ld = n_ld;
    frame(8'h60, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", {b.rxdw, b.shift_rxregs, b.load_confregs, b.load_txregs, b.shift_txregs,
                                b.tx_start, b.busy, b.err_timeout, b.err_cmd}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset partial shifts", n_srx - s_srx, 6);
    chk("reset no load", n_ld - s_ld, 0);
    base = txq.size(); s_ld = n_ld;
    frame(8'h70, 11);
    wait_idle("post-reset");
    chk("post-reset load", n_ld - s_ld, 1);
    chk("post-reset r_control", conf[87:80], 8'h70);
    chk("post-reset r_im_fm", conf[15:0], 16'h797A);
    chk("post-reset byte count", txq.size() - base, 11);
    chk("post-reset first txdw", txq[base], 8'h70);
    chk("strobe exclusive", n_multi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
